// File: rtl/mux8way_arb_pkg.sv
// mux8way_arb_pkg: shared constants and channel-index type for the 8-way mux/demux family
package mux8way_arb_pkg;
   localparam int NUM_CH = 8;
   localparam int SEL_W  = 3;
   typedef logic [SEL_W-1:0] ch_idx_t;
endpackage

// File: rtl/mux8way_arb_rr_pick8.sv
// rr_pick8: combinational round-robin pick of the first valid channel at or after ptr
//   in_valid     : per-channel request
//   ptr          : highest-priority channel this cycle
//   grant_onehot : one-hot winner (zero when nothing valid)
//   grant_idx    : winner index (0 when nothing valid)
//   any_valid    : at least one request present
module rr_pick8
   import mux8way_arb_pkg::*;
(
   input  logic [NUM_CH-1:0] in_valid,
   input  ch_idx_t           ptr,
   output logic [NUM_CH-1:0] grant_onehot,
   output ch_idx_t           grant_idx,
   output logic              any_valid
);
   ch_idx_t idx;
   always_comb begin
      grant_idx = '0;
      any_valid = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         // 3-bit add wraps mod 8, giving the ptr, ptr+1, ... scan order
         idx = ptr + ch_idx_t'(k);
         if (!any_valid && in_valid[idx]) begin
            any_valid = 1'b1;
            grant_idx = idx;
         end
      end
      grant_onehot = any_valid ? NUM_CH'(1) << grant_idx : '0;
   end
endmodule

// File: rtl/mux8way_arb.sv
// mux8way_arb: 8-to-1 round-robin collector into a single registered output slot
//   clock, reset_n : clock and synchronous active-low reset
//   in_valid/in_data/in_ready : eight producer channels, data of channel i at [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_sel/out_ready : consumer slot tagged with winning channel
//   MUX8WAY_ARB_FIXED_PRIO_EN : when defined, pointer tied to 0 (lowest channel always wins)
module mux8way_arb
   import mux8way_arb_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic [NUM_CH-1:0]       in_valid,
   input  logic [NUM_CH*WIDTH-1:0] in_data,
   output logic [NUM_CH-1:0]       in_ready,
   output logic                    out_valid,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_sel,
   input  logic                    out_ready
);
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   ch_idx_t           out_sel_q, out_sel_d;
   ch_idx_t           ptr;
   logic [NUM_CH-1:0] grant_onehot;
   ch_idx_t           grant_idx;
   logic              any_valid;
   logic              load;

   rr_pick8 u_pick (
      .in_valid     (in_valid),
      .ptr          (ptr),
      .grant_onehot (grant_onehot),
      .grant_idx    (grant_idx),
      .any_valid    (any_valid)
   );

   assign load     = !out_valid_q || out_ready;
   // reset_n gates ready so no beat is consumed in a cycle whose edge discards it
   assign in_ready = (load && reset_n) ? grant_onehot : '0;

   always_comb begin
      out_valid_d = load ? any_valid : out_valid_q;
      out_data_d  = (load && any_valid) ? in_data[grant_idx*WIDTH +: WIDTH] : out_data_q;
      out_sel_d   = (load && any_valid) ? grant_idx : out_sel_q;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
      end
   end

`ifdef MUX8WAY_ARB_FIXED_PRIO_EN
   assign ptr = '0;
`else
   ch_idx_t ptr_q, ptr_d;
   assign ptr   = ptr_q;
   assign ptr_d = (load && any_valid) ? grant_idx + ch_idx_t'(1) : ptr_q;
   always_ff @(posedge clock) begin
      if (!reset_n) ptr_q <= '0;
      else          ptr_q <= ptr_d;
   end
`endif

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux8way_arb.sv
// tb_mux8way_arb: directed plus random stimulus checked against a behavioural collector model
module tb_mux8way_arb;
   localparam int W = 16;
   logic           clock = 1'b0;
   logic           reset_n = 1'b0;
   logic [7:0]     in_valid = '0;
   logic [8*W-1:0] in_data = '0;
   logic [7:0]     in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic [2:0]     out_sel;
   logic           out_ready = 1'b0;
   int             n_cmp = 0;
   int             n_bad = 0;
   int             mptr = 0;
   bit             mv = 0;
   logic [W-1:0]   md = '0;
   int             ms = 0;
   int             win;
   logic [7:0]     exp_rdy;

   mux8way_arb #(.WIDTH(W)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int i, input logic [W-1:0] d);
      in_data[i*W +: W] = d;
   endtask

   // One cycle: predict in_ready from model state, compare, then advance model across the edge.
   task automatic step();
      #1;
      win = -1;
      for (int k = 0; k < 8; k++)
         if (win < 0 && in_valid[(mptr + k) % 8]) win = (mptr + k) % 8;
      exp_rdy = (reset_n && (!mv || out_ready) && win >= 0) ? 8'(1 << win) : 8'h00;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(mv));
      check("out_sel", 32'(out_sel), 32'(ms));
      check("out_data", 32'(out_data), 32'(md));
      @(posedge clock);
      if (!reset_n) begin
         mv = 0; md = '0; ms = 0; mptr = 0;
      end else if (!mv || out_ready) begin
         if (win >= 0) begin
            mv = 1;
            md = in_data[win*W +: W];
            ms = win;
`ifndef MUX8WAY_ARB_FIXED_PRIO_EN
            mptr = (win + 1) % 8;
`endif
         end else mv = 0;
      end
      #1;
   endtask

   initial begin
      // reset with all channels requesting
      in_valid = 8'hFF;
      for (int i = 0; i < 8; i++) set_ch(i, 16'h0100 + 16'(i));
      @(posedge clock);
      #1;
      step();
      step();
      check("rst_valid", 32'(out_valid), 32'd0);
      reset_n = 1'b1;
      out_ready = 1'b1;
      in_valid = 8'h00;
      step();
      // single channel 5
      in_valid = 8'h20;
      set_ch(5, 16'hA5A5);
      step();
      in_valid = 8'h00;
      check("single_sel", 32'(out_sel), 32'd5);
      check("single_data", 32'(out_data), 32'hA5A5);
      // drain to empty, then channel 0
      step();
      check("drain_empty", 32'(out_valid), 32'd0);
      in_valid = 8'h01;
      step();
      in_valid = 8'h00;
      check("refill_sel", 32'(out_sel), 32'd0);
      step();
      // rotation with everybody requesting
      for (int i = 0; i < 8; i++) set_ch(i, 16'h0100 + 16'(i));
      in_valid = 8'hFF;
      for (int i = 0; i < 10; i++) step();
      in_valid = 8'h00;
      step();
      // backpressure: get sel=2 into slot, then stall
      reset_n = 1'b0;
      step();
      reset_n = 1'b1;
      in_valid = 8'h04;
      step();
      check("bp_sel2", 32'(out_sel), 32'd2);
      out_ready = 1'b0;
      in_valid = 8'h81;
      for (int i = 0; i < 3; i++) step();
      check("bp_hold", 32'(out_sel), 32'd2);
      out_ready = 1'b1;
      step();
`ifdef MUX8WAY_ARB_FIXED_PRIO_EN
      check("bp_refill", 32'(out_sel), 32'd0);
`else
      check("bp_refill", 32'(out_sel), 32'd7);
`endif
      check("bp_nobubble", 32'(out_valid), 32'd1);
      in_valid = 8'h00;
      step();
`ifdef MUX8WAY_ARB_FIXED_PRIO_EN
      in_valid = 8'h0A;
      for (int i = 0; i < 5; i++) begin
         step();
         check("fixed_sel", 32'(out_sel), 32'd1);
      end
      in_valid = 8'h00;
      step();
`endif
      // random traffic with producers that hold until accepted
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (exp_rdy[i]) in_valid[i] = 1'b0;
            if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
               in_valid[i] = 1'b1;
               set_ch(i, 16'($urandom));
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         reset_n = ($urandom_range(0, 99) != 0);
         step();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
